// File: rtl/fifo_drain_serializer.sv
// Pops up to NUM_WAY addr/data entries per fetch into a group buffer and replays them one per cycle
// on a valid/ready stream; the next group is fetched on the final accepted beat so groups run back to back.
module fifo_drain_serializer #(
   parameter int NUM_WAY = 3,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 6,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fifo_empty,
   input  logic [NUM_WAY-1:0]        fifo_near_empty_arr,
   input  logic [NUM_WAY-1:0]        fifo_grant,
   input  logic [NUM_WAY*ADDR_W-1:0] fifo_addr,
   input  logic [NUM_WAY*DATA_W-1:0] fifo_data,
   output logic [NUM_WAY-1:0]        ren,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDR_W-1:0]         out_addr,
   output logic [DATA_W-1:0]         out_data,
   output logic [CNT_W-1:0]          beat_cnt,
   output logic                      grant_err
);

   localparam int CW = $clog2(NUM_WAY + 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   buf_addr_q [NUM_WAY];
   logic [ADDR_W-1:0]   buf_addr_d [NUM_WAY];
   logic [DATA_W-1:0]   buf_data_q [NUM_WAY];
   logic [DATA_W-1:0]   buf_data_d [NUM_WAY];
   logic [CW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       count_q, count_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                grant_err_q, grant_err_d;

   logic                hs, last_beat, fetch_op, grant_legal;
   logic [CW-1:0]       grant_span;

   always_comb begin
      hs          = (state_q == DRAIN) && out_ready;
      last_beat   = ((idx_q + CW'(1)) == count_q);
      fetch_op    = (state_q == IDLE) || (hs && last_beat);
      ren         = (fetch_op && !fifo_empty && !flush && !rst) ? ~fifo_near_empty_arr : '0;

      // Illegal masks are still captured positionally, so the span runs to the highest granted lane.
      grant_span = '0;
      for (int i = 0; i < NUM_WAY; i++) begin
         if (fifo_grant[i]) grant_span = CW'(i + 1);
      end
      grant_legal = ((fifo_grant & ~ren) == '0) &&
                    ((fifo_grant & (fifo_grant + NUM_WAY'(1))) == '0);

      state_d     = state_q;
      idx_d       = idx_q;
      count_d     = count_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      beat_cnt_d  = beat_cnt_q + CNT_W'(hs);
      grant_err_d = grant_err_q | ~grant_legal;

      if (flush) begin
         state_d = IDLE;
         idx_d   = '0;
         count_d = '0;
      end else if (fetch_op) begin
         for (int i = 0; i < NUM_WAY; i++) begin
            if (fifo_grant[i]) begin
               buf_addr_d[i] = fifo_addr[i*ADDR_W +: ADDR_W];
               buf_data_d[i] = fifo_data[i*DATA_W +: DATA_W];
            end
         end
         idx_d   = '0;
         count_d = grant_span;
         if (grant_span != '0) begin
            state_d    = DRAIN;
            out_addr_d = buf_addr_d[0];
            out_data_d = buf_data_d[0];
         end else begin
            state_d = IDLE;
         end
      end else if (hs) begin
         idx_d = idx_q + CW'(1);
         for (int i = 0; i < NUM_WAY; i++) begin
            if (CW'(i) == idx_d) begin
               out_addr_d = buf_addr_q[i];
               out_data_d = buf_data_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         count_q     <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         beat_cnt_q  <= '0;
         grant_err_q <= 1'b0;
         for (int i = 0; i < NUM_WAY; i++) begin
            buf_addr_q[i] <= '0;
            buf_data_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         count_q     <= count_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         beat_cnt_q  <= beat_cnt_d;
         grant_err_q <= grant_err_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign out_valid = (state_q == DRAIN);
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign beat_cnt  = beat_cnt_q;
   assign grant_err = grant_err_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench: a tiny FIFO model answers ren with a grant; entry k carries addr 16+k, data 32+k.
module tb_fifo_drain_serializer;

   logic        clk;
   logic        rst;
   logic        fifo_empty;
   logic [2:0]  fifo_near_empty_arr;
   logic [2:0]  fifo_grant;
   logic [17:0] fifo_addr;
   logic [17:0] fifo_data;
   logic [2:0]  ren;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_addr;
   logic [5:0]  out_data;
   logic [15:0] beat_cnt;
   logic        grant_err;

   int          rd_ptr = 0;
   int          wr_ptr = 0;
   logic        force_en = 1'b0;
   logic [2:0]  force_grant = 3'b000;
   int          n_chk = 0;
   int          n_pass = 0;

   fifo_drain_serializer dut (
      .clk                 (clk),
      .rst                 (rst),
      .fifo_empty          (fifo_empty),
      .fifo_near_empty_arr (fifo_near_empty_arr),
      .fifo_grant          (fifo_grant),
      .fifo_addr           (fifo_addr),
      .fifo_data           (fifo_data),
      .ren                 (ren),
      .flush               (flush),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_addr            (out_addr),
      .out_data            (out_data),
      .beat_cnt            (beat_cnt),
      .grant_err           (grant_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      for (int i = 0; i < 3; i++) begin
         fifo_near_empty_arr[i]   = (i >= (wr_ptr - rd_ptr));
         fifo_addr[i*6 +: 6]      = 6'(16 + rd_ptr + i);
         fifo_data[i*6 +: 6]      = 6'(32 + rd_ptr + i);
      end
      fifo_grant = force_en ? force_grant : ren;
   end

   always @(posedge clk) begin
      if (!rst) rd_ptr <= rd_ptr + (force_en ? $countones(ren) : $countones(fifo_grant));
   end

   function automatic logic [5:0] ea(input int k);
      return 6'(16 + k);
   endfunction

   function automatic logic [5:0] ed(input int k);
      return 6'(32 + k);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic beat(input string tag, input int k);
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_addr"}, 32'(out_addr), 32'(ea(k)));
      chk({tag, "_data"}, 32'(out_data), 32'(ed(k)));
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_addr", 32'(out_addr), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_bcnt", 32'(beat_cnt), 32'd0);
      chk("rst_gerr", 32'(grant_err), 32'd0);
      chk("rst_ren", 32'(ren), 32'd0);
      rst = 1'b0;
      #1 chk("idle_empty_ren", 32'(ren), 32'd0);

      // Five entries: 3-lane group then 2-lane group with no bubble
      @(negedge clk);
      wr_ptr = 5;
      #1 chk("t1_ren0", 32'(ren), 32'b111);
      step(); beat("t1_a0", 0); chk("t1_ren_mid", 32'(ren), 32'd0);
      step(); beat("t1_a1", 1);
      step(); beat("t1_a2", 2); chk("t1_ren_last", 32'(ren), 32'b011);
      step(); beat("t1_a3", 3); chk("t1_bcnt3", 32'(beat_cnt), 32'd3);
      step(); beat("t1_a4", 4); chk("t1_ren_end", 32'(ren), 32'd0);
      step(); chk("t1_vld_end", 32'(out_valid), 32'd0); chk("t1_bcnt5", 32'(beat_cnt), 32'd5);

      // Single entry
      wr_ptr = 6;
      #1 chk("t2_ren", 32'(ren), 32'b001);
      step(); beat("t2_a5", 5); chk("t2_ren_last", 32'(ren), 32'd0);
      step(); chk("t2_idle", 32'(out_valid), 32'd0); chk("t2_ren_idle", 32'(ren), 32'd0);
      chk("t2_bcnt", 32'(beat_cnt), 32'd6);

      // Backpressure mid-group with more data waiting
      wr_ptr = 9;
      #1 chk("t3_ren", 32'(ren), 32'b111);
      step(); beat("t3_a6", 6);
      step(); beat("t3_a7", 7);
      out_ready = 1'b0;
      wr_ptr    = 11;
      for (int s = 0; s < 4; s++) begin
         step();
         beat("t3_hold", 7);
         chk("t3_hold_bcnt", 32'(beat_cnt), 32'd7);
         chk("t3_hold_ren", 32'(ren), 32'd0);
      end
      out_ready = 1'b1;
      #1 chk("t3_rel_ren", 32'(ren), 32'd0);
      step(); beat("t3_a8", 8); chk("t3_ren_last", 32'(ren), 32'b011);
      step(); beat("t3_a9", 9);
      step(); beat("t3_a10", 10); chk("t3_ren_end", 32'(ren), 32'd0);
      step(); chk("t3_idle", 32'(out_valid), 32'd0); chk("t3_bcnt", 32'(beat_cnt), 32'd11);

      // Flush on the second beat of a 3-beat group
      wr_ptr = 14;
      #1 chk("t4_ren", 32'(ren), 32'b111);
      step(); beat("t4_a11", 11);
      step(); beat("t4_a12", 12);
      flush = 1'b1;
      #1 chk("t4_flush_ren", 32'(ren), 32'd0);
      step();
      flush = 1'b0;
      chk("t4_vld_drop", 32'(out_valid), 32'd0);
      chk("t4_bcnt", 32'(beat_cnt), 32'd13);
      wr_ptr = 15;
      #1 chk("t4_ren_after", 32'(ren), 32'b001);
      step(); beat("t4_a14", 14);
      step(); chk("t4_idle", 32'(out_valid), 32'd0); chk("t4_bcnt2", 32'(beat_cnt), 32'd14);

      // Illegal grant 101: slot 1 keeps its stale entry (A12)
      wr_ptr      = 18;
      force_grant = 3'b101;
      force_en    = 1'b1;
      #1 chk("t5_ren", 32'(ren), 32'b111);
      chk("t5_gerr_pre", 32'(grant_err), 32'd0);
      step();
      force_en = 1'b0;
      chk("t5_gerr", 32'(grant_err), 32'd1);
      beat("t5_b0", 15);
      step(); beat("t5_b1", 12);
      step(); beat("t5_b2", 17);
      step(); chk("t5_idle", 32'(out_valid), 32'd0);
      chk("t5_gerr_sticky", 32'(grant_err), 32'd1);
      chk("t5_bcnt", 32'(beat_cnt), 32'd17);

      // Async reset between edges in DRAIN
      wr_ptr = 21;
      #1 chk("t6_ren", 32'(ren), 32'b111);
      step(); beat("t6_a18", 18);
      step(); beat("t6_a19", 19);
      wr_ptr = 22;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_vld", 32'(out_valid), 32'd0);
      chk("t6_rst_ren", 32'(ren), 32'd0);
      chk("t6_rst_bcnt", 32'(beat_cnt), 32'd0);
      chk("t6_rst_gerr", 32'(grant_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("t6_rel_vld", 32'(out_valid), 32'd0);
      chk("t6_rel_ren", 32'(ren), 32'b001);
      step(); beat("t6_a21", 21);
      step(); chk("t6_idle", 32'(out_valid), 32'd0); chk("t6_bcnt", 32'(beat_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Downstream consumer of the multi-way addr/data FIFO.
- Each fetch pops up to NUM_WAY entries in one cycle and holds them in a local group buffer.
- Replays the group one entry per cycle on a single-lane valid/ready stream towards the image memory writer.
- Back-to-back groups have no bubble when the FIFO has data on the final beat.

Parameters:
- NUM_WAY, 3, lanes per fetch; must match the FIFO.
- ADDR_W, 6, address width per entry.
- DATA_W, 6, data width per entry.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO has no valid entries.
- fifo_near_empty_arr  input  NUM_WAY  per-lane: 1 = no entry for this lane (pattern 000/100/110/111).
- fifo_grant  input  NUM_WAY  success_out from FIFO, combinational response to ren.
- fifo_addr  input  NUM_WAY*ADDR_W  per-lane popped address.
- fifo_data  input  NUM_WAY*DATA_W  per-lane popped data.
- ren  output  NUM_WAY  per-lane pop request to FIFO.
- flush  input  1  synchronous discard of buffered group.
- out_valid  output  1  serial beat valid.
- out_ready  input  1  sink accepts beat.
- out_addr  output  ADDR_W  serial beat address.
- out_data  output  DATA_W  serial beat data.
- beat_cnt  output  CNT_W  total beats accepted by sink, wraps.
- grant_err  output  1  sticky, grant mask non-contiguous or outside ren.

Behaviour:
- States: IDLE, DRAIN.
- Reset (async, rst=1) values:
  - state = IDLE; buffer contents = 0; idx = 0; count = 0.
  - out_valid = 0; out_addr = 0; out_data = 0.
  - beat_cnt = 0; grant_err = 0; ren = 0.
- Reset mid-group discards the buffered beats; no partial replay after release.
- ren generation (combinational):
  - Fetch opportunity exists in IDLE, and in DRAIN on the last beat (idx == count-1) when out_valid & out_ready.
  - In a fetch opportunity with fifo_empty=0: ren = ~fifo_near_empty_arr.
  - Otherwise ren = 0.
  - ren depends combinationally on out_ready only in the last-beat case.
- Capture:
  - At the clock edge of a fetch opportunity, lanes with fifo_grant[i]=1 are written into buffer slot i.
  - count = popcount(fifo_grant).
  - idx = 0.
  - Next state = DRAIN if count > 0, else IDLE.
- Grant legality:
  - fifo_grant must be a subset of ren and contiguous from lane 0 (001, 011, 111 for 3-way).
  - Any other value sets grant_err (sticky until rst).
  - On an illegal grant, lanes are still captured by position; count = index of highest set bit + 1.
- DRAIN:
  - out_valid = 1; out_addr/out_data = buffer[idx], registered, stable while out_ready=0.
  - On out_ready: if idx < count-1, idx increments; if idx == count-1, either capture a new group or go to IDLE.
- Latency: first beat appears on out_valid one cycle after the capture edge; a 3-lane group occupies 3 cycles with out_ready held 1.
- beat_cnt increments on every out_valid & out_ready and wraps modulo 2^CNT_W.
- flush=1 at a clock edge:
  - state = IDLE; count = 0; out_valid = 0 next cycle.
  - ren forced to 0 in that cycle; flush has priority over capture and over handshake.
  - beat_cnt still counts a handshake occurring in the flush cycle.
- out_valid never drops without a handshake, except on flush or rst.

Test Plan:
- Reset then FIFO holding 5 entries (A0..A4), out_ready=1:
  - ren=111, grant=111 at cycle 0; serial A0,A1,A2 on cycles 1-3.
  - Cycle 3 is the last beat, so ren=011, grant=011.
  - A3,A4 on cycles 4-5; beat_cnt=5; out_valid=0 at cycle 6; no bubble between A2 and A3.
- Single entry, near_empty_arr=110:
  - ren=001, one beat out.
  - State returns to IDLE.
  - ren=000 while fifo_empty=1.
- Backpressure:
  - out_ready=0 for 4 cycles mid-group.
  - out_addr/out_data held constant; idx not advanced; beat_cnt unchanged.
  - ren stays 000 throughout.
- flush asserted on the 2nd beat of a 3-beat group:
  - out_valid=0 next cycle; remaining beat discarded.
  - Next fetch starts from IDLE with ren=~near_empty_arr.
- Illegal grant 101 with ren=111:
  - grant_err=1 and stays 1.
  - count=3; three beats emitted.
- Async reset asserted mid-DRAIN between clock edges:
  - out_valid, ren and beat_cnt go to 0 immediately.
  - After release no stale beat appears.
